// File: rtl/cipher_loader_if.sv
// Serial-load bus between the link front end and the cipher loader.
// The host side drives RXD/CLEAR; the loader returns the assembled ciphertext and status.
interface cipher_loader_if #(
  parameter int ENQLEN = 10
);
  logic                  RXD;
  logic                  CLEAR;
  logic [8*ENQLEN-1:0]   CIPHER;
  logic                  READY;
  logic                  BYTE_STB;
  logic                  FRAME_ERR;
  logic [7:0]            COUNT;

  modport master (
    output RXD, CLEAR,
    input  CIPHER, READY, BYTE_STB, FRAME_ERR, COUNT
  );

  modport slave (
    input  RXD, CLEAR,
    output CIPHER, READY, BYTE_STB, FRAME_ERR, COUNT
  );
endinterface

// File: rtl/cipher_loader.sv
// Receives ENQLEN serial bytes (idle low, start high, stop low) and packs them
// into CIPHER, first byte in the top slot, for the password-cracker decoder.
module cipher_loader #(
  parameter int ENQLEN = 10,
  parameter int CLOCK  = 650
) (
  input  logic             CLK,
  input  logic             RESET,
  cipher_loader_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RESYNC, DONE} state_t;

  state_t              state, state_nxt;
  logic                rx_p0, rx_p1, rx;
  logic [9:0]          presc;
  logic [3:0]          sub;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic [8*ENQLEN-1:0] cipher;
  logic [7:0]          count;
  logic                byte_stb, frame_err;
  logic                clr, tick;
  logic                zero_cnt, zero_sub, shift_en, commit, set_ferr;

  assign clr  = RESET || bus.CLEAR;
  assign rx   = rx_p1;
  assign tick = (presc == 10'(CLOCK));

  // Stage p0/p1: two-flop synchroniser for the asynchronous line
  always_ff @(posedge CLK) begin
    if (clr) begin
      rx_p0 <= 1'b0;
      rx_p1 <= 1'b0;
    end else begin
      rx_p0 <= bus.RXD;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    zero_cnt  = 1'b0;
    zero_sub  = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      IDLE: if (rx) begin
        zero_cnt  = 1'b1;
        state_nxt = START;
      end
      START: if (tick && sub == 4'd7) begin
        if (rx) begin
          zero_sub  = 1'b1;
          state_nxt = DATA;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: if (tick && sub == 4'd15) begin
        shift_en = 1'b1;
        if (bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (tick && sub == 4'd15) begin
        if (!rx) begin
          commit    = 1'b1;
          state_nxt = (count + 8'd1 == 8'(ENQLEN)) ? DONE : IDLE;
        end else begin
          set_ferr  = 1'b1;
          state_nxt = RESYNC;
        end
      end
      // Any high level restarts the 16-tick quiet window
      RESYNC: begin
        if (rx) zero_sub = 1'b1;
        else if (tick && sub == 4'd15) state_nxt = IDLE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing: prescaler, tick sub-counter, bit index
  always_ff @(posedge CLK) begin
    if (clr) begin
      presc   <= '0;
      sub     <= '0;
      bit_idx <= '0;
    end else begin
      if (zero_cnt || tick) presc <= '0;
      else                  presc <= presc + 10'd1;
      if (zero_cnt || zero_sub) sub <= '0;
      else if (tick)            sub <= sub + 4'd1;
      if (zero_cnt)      bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (shift_en) shift <= {rx, shift[7:1]};
  end

  // Commit stage: slot write, byte count, strobe and sticky framing flag
  always_ff @(posedge CLK) begin
    if (clr) begin
      cipher    <= '0;
      count     <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb <= commit;
      if (set_ferr) frame_err <= 1'b1;
      if (commit) begin
        count <= count + 8'd1;
        for (int n = 0; n < ENQLEN; n++) begin
          if (count == 8'(n)) cipher[8*(ENQLEN-n)-1 -: 8] <= shift;
        end
      end
    end
  end

  assign bus.CIPHER    = cipher;
  assign bus.COUNT     = count;
  assign bus.BYTE_STB  = byte_stb;
  assign bus.FRAME_ERR = frame_err;
  assign bus.READY     = (state == DONE);

endmodule

// File: tb/tb_cipher_loader.sv
// Directed bench for cipher_loader: ENQLEN=3, CLOCK=3 (64 CLK per bit, 640 CLK per frame).
module tb_cipher_loader;

  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   stb_n = 0;
  int   stb_cyc[$];
  int   stb_count[$];
  logic stb_ready[$];
  logic prev_stb = 1'b0;
  int   last_start = 0;

  cipher_loader_if #(.ENQLEN(3)) bus ();

  cipher_loader #(.ENQLEN(3), .CLOCK(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: records cycle, count and READY at every committed byte
  always @(negedge CLK) begin
    if (bus.BYTE_STB === 1'b1) begin
      chk("stb_width", {63'd0, prev_stb}, 64'd0);
      stb_n++;
      stb_cyc.push_back(cyc);
      stb_count.push_back(int'(bus.COUNT));
      stb_ready.push_back(bus.READY);
    end
    prev_stb = bus.BYTE_STB;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    bus.RXD = v;
    step(n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cipher"}, 64'(bus.CIPHER), 64'd0);
    chk({tag, "_count"},  64'(bus.COUNT), 64'd0);
    chk({tag, "_ready"},  64'(bus.READY), 64'd0);
    chk({tag, "_stb"},    64'(bus.BYTE_STB), 64'd0);
    chk({tag, "_ferr"},   64'(bus.FRAME_ERR), 64'd0);
  endtask

  // One frame; bad_stop holds the stop bit high for 2 bits then low for 2 bits;
  // rst_bit pulses RESET in the middle of that data bit (-1 = never)
  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int rst_bit);
    last_start = cyc;
    drive(1'b1, 64);
    for (int k = 0; k < 8; k++) begin
      if (k == rst_bit) begin
        bus.RXD = b[k];
        step(32);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        chk_all_zero("rst_mid");
        step(31);
      end else begin
        drive(b[k], 64);
      end
    end
    if (bad_stop) begin
      drive(1'b1, 128);
      drive(1'b0, 128);
    end else begin
      drive(1'b0, 64);
    end
  endtask

  task automatic pulse_clear();
    bus.CLEAR = 1'b1;
    step(1);
    bus.CLEAR = 1'b0;
  endtask

  initial begin
    int   base;
    int   start0;
    logic [2:0] st;

    bus.RXD   = 1'b0;
    bus.CLEAR = 1'b0;
    RESET     = 1'b1;
    step(5);
    chk_all_zero("reset");
    RESET = 1'b0;
    step(10);

    // Normal load 0x44 0x41 0x5A back-to-back
    base = stb_n;
    send_byte(8'h44, 1'b0, -1);
    start0 = last_start;
    send_byte(8'h41, 1'b0, -1);
    send_byte(8'h5A, 1'b0, -1);
    step(20);
    chk("load_stb_n", 64'(stb_n - base), 64'd3);
    if (stb_n - base >= 3) begin
      chk("load_lat0",   64'(stb_cyc[base] - start0), 64'd611);
      chk("load_gap1",   64'(stb_cyc[base+1] - stb_cyc[base]), 64'd640);
      chk("load_gap2",   64'(stb_cyc[base+2] - stb_cyc[base+1]), 64'd640);
      chk("load_cnt1",   64'(stb_count[base]), 64'd1);
      chk("load_cnt2",   64'(stb_count[base+1]), 64'd2);
      chk("load_cnt3",   64'(stb_count[base+2]), 64'd3);
      chk("load_rdy2",   64'(stb_ready[base+1]), 64'd0);
      chk("load_rdy3",   64'(stb_ready[base+2]), 64'd1);
    end else begin
      chk("load_stb_present", 64'(stb_n - base), 64'd3);
    end
    chk("load_cipher", 64'(bus.CIPHER), 64'h44415A);
    chk("load_count",  64'(bus.COUNT), 64'd3);
    chk("load_ready",  64'(bus.READY), 64'd1);
    chk("load_ferr",   64'(bus.FRAME_ERR), 64'd0);

    // After READY the line is ignored
    base = stb_n;
    send_byte(8'h11, 1'b0, -1);
    step(20);
    chk("post_stb_n",  64'(stb_n - base), 64'd0);
    chk("post_cipher", 64'(bus.CIPHER), 64'h44415A);
    chk("post_ready",  64'(bus.READY), 64'd1);

    pulse_clear();
    chk_all_zero("clear");

    send_byte(8'h01, 1'b0, -1);
    send_byte(8'h02, 1'b0, -1);
    send_byte(8'h03, 1'b0, -1);
    step(20);
    chk("reload_cipher", 64'(bus.CIPHER), 64'h010203);
    chk("reload_ready",  64'(bus.READY), 64'd1);

    // Glitch: 20 CLK high pulse is rejected at the start-bit midpoint
    pulse_clear();
    step(10);
    base = stb_n;
    drive(1'b1, 20);
    drive(1'b0, 100);
    st = dut.state;
    chk("glitch_stb_n", 64'(stb_n - base), 64'd0);
    chk("glitch_count", 64'(bus.COUNT), 64'd0);
    chk("glitch_state", 64'(st), 64'd0);
    send_byte(8'h44, 1'b0, -1);
    step(20);
    chk("glitch_after_count",  64'(bus.COUNT), 64'd1);
    chk("glitch_after_cipher", 64'(bus.CIPHER), 64'h440000);

    // Framing error on 0x41, then 0x42 lands in slot 0
    pulse_clear();
    step(10);
    base = stb_n;
    send_byte(8'h41, 1'b1, -1);
    chk("ferr_set",    64'(bus.FRAME_ERR), 64'd1);
    chk("ferr_count0", 64'(bus.COUNT), 64'd0);
    send_byte(8'h42, 1'b0, -1);
    step(20);
    chk("ferr_sticky", 64'(bus.FRAME_ERR), 64'd1);
    chk("ferr_count",  64'(bus.COUNT), 64'd1);
    chk("ferr_cipher", 64'(bus.CIPHER), 64'h420000);
    chk("ferr_stb_n",  64'(stb_n - base), 64'd1);

    // RESET during data bit 4 of the second byte (upper nibble of 0x0F is low)
    pulse_clear();
    step(10);
    send_byte(8'h3C, 1'b0, -1);
    chk("rstmid_pre_count", 64'(bus.COUNT), 64'd1);
    base = stb_n;
    send_byte(8'h0F, 1'b0, 4);
    step(20);
    chk("rstmid_stb_n", 64'(stb_n - base), 64'd0);
    chk("rstmid_ferr",  64'(bus.FRAME_ERR), 64'd0);
    chk("rstmid_count", 64'(bus.COUNT), 64'd0);
    send_byte(8'hA5, 1'b0, -1);
    send_byte(8'h3C, 1'b0, -1);
    send_byte(8'h7E, 1'b0, -1);
    step(20);
    chk("rstmid_cipher", 64'(bus.CIPHER), 64'hA53C7E);
    chk("rstmid_ready",  64'(bus.READY), 64'd1);
    chk("rstmid_final",  64'(bus.COUNT), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cipher_loader.md
# cipher_loader

Serial receiver that loads the encrypted string into the password cracker at run time, replacing a synthesis-time ciphertext parameter. It deserialises `ENQLEN` bytes arriving on `RXD` and presents them as one packed vector `CIPHER`, in the layout the decoder consumes. It raises `READY` once the vector is complete. It uses the same line convention and bit timing as the transmit side of the link (`Serial`): idle low, start bit high, 8 data bits LSB first, stop bit low.

## Interface
- `ENQLEN`, default 10: number of ciphertext bytes to collect (1..255).
- `CLOCK`, default 650: prescaler terminal value; one tick every `CLOCK+1` CLK cycles; 16 ticks per bit; must be ≤ 1023.
- `CLK`  in  1  system clock.
- `RESET`  in  1  reset, synchronous, active-high.
- `RXD`  in  1  serial line, asynchronous to CLK.
- `CLEAR`  in  1  synchronous restart of the load; same effect as RESET on all state and outputs.
- `CIPHER`  out  8*ENQLEN  collected bytes; first received byte in `[8*ENQLEN-1 -: 8]`, last in `[7:0]`.
- `READY`  out  1  level; high once `ENQLEN` bytes are committed.
- `BYTE_STB`  out  1  one-cycle pulse per committed byte.
- `FRAME_ERR`  out  1  sticky; set on a bad stop bit.
- `COUNT`  out  8  number of bytes committed so far.

## Operation
- `RXD` passes through a 2-flop synchroniser. All decisions use the synchronised value `rx`.
- Prescaler: 10-bit counter 0..`CLOCK`. Tick fires at terminal. Sub-counter 4 bits (0..15) counts ticks. Both counters are zeroed on start detection.
- The FSM has six states.
  - IDLE: waits for `rx`=1. On detection, zero the counters and go to START.
  - START: at tick 8 (bit midpoint), sample `rx`. If 1, go to DATA with the sub-counter zeroed. If 0, it was a glitch: go to IDLE with no output change.
  - DATA: every 16 ticks, sample `rx` into the shift register, LSB first. After 8 bits, go to STOP.
  - STOP: after 16 ticks, sample `rx`.
    - If 0: commit the byte. The shifted byte is written to slot `COUNT`, `COUNT`+1, and `BYTE_STB` pulses. Go to DONE if the new `COUNT`==`ENQLEN`, else to IDLE.
    - If 1: set `FRAME_ERR`, discard the byte, go to RESYNC.
  - RESYNC: wait for `rx`=0 sustained for 16 consecutive ticks, then go to IDLE. This prevents a high level being mistaken for a start bit.
  - DONE: `READY`=1. `RXD` is ignored. Leave only via CLEAR or RESET.
- Slot addressing: byte n (0-based) is written to `CIPHER[8*(ENQLEN-n)-1 -: 8]`. Other slots are untouched.
- Priority when signals coincide: RESET > CLEAR > FSM activity.
- Reset/CLEAR values:
  - `CIPHER`=0, `READY`=0, `BYTE_STB`=0, `FRAME_ERR`=0, `COUNT`=0.
  - FSM in IDLE, counters 0, synchroniser flops 0.
- Reset or CLEAR mid-byte discards the partial byte. Reception restarts only on a fresh start bit seen after release.
- `FRAME_ERR` never clears itself. It does not block further bytes.
- `COUNT` never exceeds `ENQLEN`. No wrap-around.

## Timing
- Start detection happens 2 CLK after the `RXD` rising edge (synchroniser latency). Call the detection cycle T0.
- Start-bit sample: T0 + 8*(`CLOCK`+1).
- Data bit k sample: T0 + (24+16k)*(`CLOCK`+1), for k=0..7.
- Stop sample: T0 + 152*(`CLOCK`+1).
- `CIPHER`, `COUNT`, `BYTE_STB` and `READY` all update on the clock edge following the stop sample. `BYTE_STB` is high for exactly that one cycle.
- Back-to-back frames are supported. A start bit immediately after the stop bit (stop width 16 ticks) is detected as soon as the FSM is in IDLE.
- `READY` rises in the same cycle as the final `BYTE_STB`. It stays high until CLEAR or RESET. The downstream decoder holds off counting while `READY`=0.

## Test plan
All scenarios use `CLOCK`=3 (4 CLK per tick, 64 CLK per bit).
- Normal load: `ENQLEN`=3; send 0x44, 0x41, 0x5A back-to-back.
  - -> Exactly 3 `BYTE_STB` pulses, spaced 640 CLK apart.
  - -> `COUNT` 1→2→3 and `CIPHER`=24'h44415A.
  - -> `READY` rises with the 3rd strobe; `FRAME_ERR`=0.
- Glitch rejection: `RXD` high for 20 CLK, then low.
  - -> No strobe; `COUNT`=0; FSM back in IDLE.
  - -> A following valid 0x44 is received correctly.
- Framing error: send 0x41 with the stop bit driven high for 2 bit times, then low for 2 bit times, then send 0x42.
  - -> `FRAME_ERR`=1; 0x41 is not committed.
  - -> 0x42 is committed to slot 0 (`CIPHER[23:16]`=0x42); `COUNT`=1.
- Post-READY and CLEAR: after the normal load, send 0x11.
  - -> `CIPHER` stays unchanged; no strobe.
  - -> Pulse CLEAR: all outputs become 0.
  - -> Reload 0x01, 0x02, 0x03 -> `CIPHER`=24'h010203, `READY`=1.
- Reset mid-byte: assert RESET for 1 CLK during data bit 4 of the second byte.
  - -> All outputs 0 on the next cycle.
  - -> Remainder of the frame produces no strobe, or at most a `FRAME_ERR`-free resync.
  - -> A fresh 3-byte load then completes with the correct `CIPHER`.
